// File: rtl/serial_pattern_tx_if.sv
// Bundle between a pattern source and the serial transmitter: request/cancel,
// the word to send with its repeat count, and the registered serial outputs.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] reps;
  logic             dout;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, data, reps,
    input  dout, busy, done
  );

  modport slave (
    input  start, abort, data, reps,
    output dout, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// MSB-first serial pattern transmitter with back-to-back word repeats; first bit one cycle
// after the accepting edge, start is ignored while busy (no queueing), abort cancels at once.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_pattern_tx_if.slave  bus
);
  localparam int BW = $clog2(WIDTH);

  localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0]    BIT_ONE  = 1;
  localparam logic [CNT_W-1:0] REP_ONE  = 1;

  // One-hot encoding so any corrupted value lands in the recovery branch.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      word_q    <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      dout_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // shift_q holds the bits still to go out after the one currently on dout.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    word_d    = word_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    dout_d    = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          word_d    = bus.data;
          shift_d   = {bus.data[WIDTH-2:0], 1'b0};
          bit_cnt_d = BIT_LAST;
          rep_cnt_d = bus.reps;
          dout_d    = bus.data[WIDTH-1];
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bit_cnt_q == '0) begin
          if (rep_cnt_q != '0) begin
            shift_d   = {word_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = BIT_LAST;
            rep_cnt_d = rep_cnt_q - REP_ONE;
            dout_d    = word_q[WIDTH-1];
            busy_d    = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - BIT_ONE;
          dout_d    = shift_q[WIDTH-1];
          busy_d    = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: vector table for single-word, ignored-start and
// abort cases, hand sequences for repeats, back-to-back starts and mid-run reset.
module tb_serial_pattern_tx;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  serial_pattern_tx #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          start;
    logic          abort;
    logic [W-1:0]  data;
    logic [CW-1:0] reps;
    logic [2:0]    exp;   // {dout, busy, done} after the edge
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  int errors = 0;
  int checks = 0;

  logic [7:0] det_hist;
  int         det_cnt;

  logic obs_dout [200];
  logic obs_busy [200];
  logic obs_done [200];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2:0] outs();
    return {bus.dout, bus.busy, bus.done};
  endfunction

  // Overlapping 01010101 detector fed from dout.
  task automatic det_clear();
    det_hist = 8'hFF;
    det_cnt  = 0;
  endtask

  task automatic det_feed(input logic b);
    det_hist = {det_hist[6:0], b};
    if (det_hist == 8'b01010101) det_cnt++;
  endtask

  task automatic set_vec(input int i, input logic s, input logic a, input logic [W-1:0] d,
                         input logic [2:0] e);
    vecs[i].start = s;
    vecs[i].abort = a;
    vecs[i].data  = d;
    vecs[i].reps  = '0;
    vecs[i].exp   = e;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      obs_dout[i] = bus.dout;
      obs_busy[i] = bus.busy;
      obs_done[i] = bus.done;
      det_feed(bus.dout);
      step();
    end
  endtask

  // Sample 0 is the cycle after the accepting edge.
  task automatic check_run(input string name, input logic [W-1:0] pat, input int words,
                           input int nsamp);
    int bad;
    int nbusy;
    int ndone;
    logic [2:0] bi;
    logic [2:0] exp;
    bad   = 0;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < nsamp; i++) begin
      if (i < words * W) begin
        bi  = 3'(7 - (i % 8));
        exp = {pat[bi], 1'b1, 1'b0};
      end else if (i == words * W) begin
        exp = 3'b101;
      end else begin
        exp = 3'b100;
      end
      if ({obs_dout[i], obs_busy[i], obs_done[i]} !== exp) bad++;
      if (obs_busy[i]) nbusy++;
      if (obs_done[i]) ndone++;
    end
    check({name, "_bad_cycles"}, bad, 0);
    check({name, "_busy_cycles"}, nbusy, words * W);
    check({name, "_done_pulses"}, ndone, 1);
  endtask

  task automatic start_word(input logic [W-1:0] d, input logic [CW-1:0] r);
    bus.start = 1'b1;
    bus.data  = d;
    bus.reps  = r;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.data  = '0;
    bus.reps  = '0;
    det_clear();

    // Single word 0x55
    set_vec(0, 1, 0, 8'h55, 3'b010);
    set_vec(1, 0, 0, 8'h00, 3'b110);
    set_vec(2, 0, 0, 8'h00, 3'b010);
    set_vec(3, 0, 0, 8'h00, 3'b110);
    set_vec(4, 0, 0, 8'h00, 3'b010);
    set_vec(5, 0, 0, 8'h00, 3'b110);
    set_vec(6, 0, 0, 8'h00, 3'b010);
    set_vec(7, 0, 0, 8'h00, 3'b110);
    set_vec(8, 0, 0, 8'h00, 3'b101);
    set_vec(9, 0, 0, 8'h00, 3'b100);
    // 0xA5 with a start/0xFF arriving mid-word
    set_vec(10, 1, 0, 8'hA5, 3'b110);
    set_vec(11, 0, 0, 8'h00, 3'b010);
    set_vec(12, 0, 0, 8'h00, 3'b110);
    set_vec(13, 1, 0, 8'hFF, 3'b010);
    set_vec(14, 1, 0, 8'hFF, 3'b010);
    set_vec(15, 0, 0, 8'h00, 3'b110);
    set_vec(16, 0, 0, 8'h00, 3'b010);
    set_vec(17, 0, 0, 8'h00, 3'b110);
    set_vec(18, 0, 0, 8'h00, 3'b101);
    set_vec(19, 0, 0, 8'h00, 3'b100);
    // Abort after bit 4, abort in idle, start+abort in idle
    set_vec(20, 1, 0, 8'hA5, 3'b110);
    set_vec(21, 0, 0, 8'h00, 3'b010);
    set_vec(22, 0, 0, 8'h00, 3'b110);
    set_vec(23, 0, 0, 8'h00, 3'b010);
    set_vec(24, 0, 1, 8'h00, 3'b100);
    set_vec(25, 0, 0, 8'h00, 3'b100);
    set_vec(26, 0, 1, 8'h00, 3'b100);
    set_vec(27, 1, 1, 8'hA5, 3'b110);
    set_vec(28, 0, 1, 8'h00, 3'b100);
    set_vec(29, 0, 0, 8'h00, 3'b100);

    // Reset takes effect without a clock edge
    #3 rst = 1'b1;
    #1 check("reset_async", 32'(outs()), 32'(3'b100));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("idle_after_reset_%0d", i), 32'(outs()), 32'(3'b100));
    end

    det_clear();
    for (int i = 0; i < NVEC; i++) begin
      bus.start = vecs[i].start;
      bus.abort = vecs[i].abort;
      bus.data  = vecs[i].data;
      bus.reps  = vecs[i].reps;
      step();
      det_feed(bus.dout);
      check($sformatf("vec_%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("table_detector_hits", det_cnt, 1);

    // Three words of 0x55
    det_clear();
    start_word(8'h55, 4'd2);
    observe(30);
    check_run("reps2", 8'h55, 3, 30);
    check("reps2_detector_hits", det_cnt, 9);

    // Maximum repeat count: 16 words
    start_word(8'h81, 4'd15);
    observe(132);
    check_run("reps15", 8'h81, 16, 132);

    // start held high: one idle-high gap per word, coinciding with done
    begin
      int bad;
      int ndone;
      logic [7:0] pat;
      logic [2:0] bi;
      logic [2:0] exp;
      bit drained;
      pat = 8'hC3;
      bus.start = 1'b1;
      bus.data  = pat;
      bus.reps  = '0;
      step();
      observe(27);
      bus.start = 1'b0;
      bad   = 0;
      ndone = 0;
      for (int i = 0; i < 27; i++) begin
        if ((i % 9) < 8) begin
          bi  = 3'(7 - (i % 9));
          exp = {pat[bi], 1'b1, 1'b0};
        end else begin
          exp = 3'b101;
        end
        if ({obs_dout[i], obs_busy[i], obs_done[i]} !== exp) bad++;
        if (obs_done[i]) ndone++;
      end
      check("b2b_bad_cycles", bad, 0);
      check("b2b_done_pulses", ndone, 3);
      drained = 1'b0;
      for (int i = 0; i < 40 && !drained; i++) begin
        if (!bus.busy) drained = 1'b1;
        else step();
      end
      check("b2b_drain_busy", 32'(bus.busy), 0);
      step();
    end

    // Reset in the middle of word 2, then a fresh four-word run
    start_word(8'hA5, 4'd3);
    observe(10);
    rst = 1'b1;
    #1 check("midrun_reset_async", 32'(outs()), 32'(3'b100));
    @(negedge clk);
    check("midrun_reset_held", 32'(outs()), 32'(3'b100));
    rst = 1'b0;
    step();
    check("midrun_after_release", 32'(outs()), 32'(3'b100));
    start_word(8'hA5, 4'd3);
    observe(36);
    check_run("fresh_after_reset", 8'hA5, 4, 36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
